fir_cfg_ctrl: RTL
=================

FIR_CFG_CTRL -- requirements
Module: fir_cfg_ctrl

Interface
REQ-001 SHALL have parameter COEF_AW, default 8, meaning coefficient address width per bank (256 taps).
REQ-002 SHALL have ports: clk1  in  1  compute/config clock (single clock domain).
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: cfg_valid in 1, cfg_ready out 1, cfg_addr in 10, cfg_data in 32; host write channel.
REQ-005 SHALL have port: sample_tick  in  1  one-cycle pulse marking an output-sample boundary (safe swap point).
REQ-006 SHALL have ports: coef_wr_en out 1, coef_wr_addr out COEF_AW+1, coef_wr_data out 32; write port into ping-pong coefficient RAM.
REQ-007 SHALL have port: active_bank  out  1  bank the FIR lanes read, used as MSB of lane param_addr.
REQ-008 SHALL have ports: tap_len out 8, down_sample out 8, bypass out 1, pcm_out_shift out 4; active FIR controls.
REQ-009 SHALL have ports: busy out 1 (commit pending), commit_done out 1 (swap pulse), cfg_err out 1 (sticky).

Function
REQ-010 SHALL accept a write when cfg_valid && cfg_ready in the same clk1 cycle.
REQ-011 Address map SHALL be: 0x000-0x0FF coefficient; 0x100 shadow tap_len = data[7:0]; 0x101 shadow down_sample = data[7:0]; 0x102 shadow {bypass, pcm_out_shift} = data[4:0]; 0x103 commit; other addresses -> set cfg_err, no other effect.
REQ-012 Coefficient write SHALL produce coef_wr_en=1 exactly one cycle after acceptance, coef_wr_addr = {~active_bank, cfg_addr[7:0]}, coef_wr_data = cfg_data; coef_wr_en=0 otherwise.
REQ-013 The active bank SHALL never be written.
REQ-014 FSM states SHALL be IDLE, PENDING, SWAP.
REQ-015 IDLE: cfg_ready=1; accepted commit -> PENDING next cycle; sample_tick ignored.
REQ-016 PENDING: cfg_ready=0, busy=1; sample_tick -> SWAP next cycle.
REQ-017 SWAP (one cycle): active_bank toggles, shadow controls copied to active outputs, commit_done=1, cfg_ready=0; -> IDLE.
REQ-018 Active outputs and active_bank SHALL change only on the IDLE/SWAP exit edge; fully atomic, all four controls update in the same cycle.
REQ-019 sample_tick in the same cycle a commit is accepted SHALL NOT trigger the swap; next sample_tick does.
REQ-020 Coefficient write accepted in the cycle before commit SHALL still complete its coef_wr_en cycle before the swap.
REQ-021 After a swap the new shadow bank holds stale coefficients; block SHALL NOT copy banks.
REQ-022 cfg_err SHALL clear only on reset.

Reset
REQ-023 On rst: state IDLE, cfg_ready=0 while rst high then 1, active_bank=0, tap_len=1, down_sample=1, bypass=1, pcm_out_shift=0, shadow registers equal active values, coef_wr_en=0, busy=0, commit_done=0, cfg_err=0.
REQ-024 rst asserted in PENDING or SWAP SHALL abort the commit; no partial update of active outputs.

Configuration
REQ-025 Macro FIR_CFG_RANGE_CHECK_EN: when defined, writes of 0 to tap_len or down_sample SHALL set cfg_err and leave the shadow value unchanged; tap_len write greater than 2^COEF_AW-1 impossible (8 bits) is accepted.
REQ-026 Without FIR_CFG_RANGE_CHECK_EN, any value SHALL be stored into shadow registers and cfg_err SHALL only flag unmapped addresses.

Verification
REQ-027 Reset release -> active_bank=0, tap_len=1, down_sample=1, bypass=1, shift=0, cfg_ready=1.
REQ-028 Write 0x005=0xDEADBEEF with active_bank=0 -> one cycle later coef_wr_en=1, coef_wr_addr=0x105, data 0xDEADBEEF.
REQ-029 Write 0x100=40, 0x101=4, 0x102=0x03, 0x103, then sample_tick after 10 cycles -> outputs unchanged, busy=1, cfg_ready=0 until tick; SWAP cycle commit_done=1; then tap_len=40, down_sample=4, bypass=0, shift=3, active_bank=1.
REQ-030 Commit and sample_tick same cycle -> no swap; second tick 5 cycles later -> swap.
REQ-031 Assert rst during PENDING -> outputs return to reset values, active_bank=0, no commit_done.
REQ-032 Write 0x1FF -> cfg_err=1 persisting; with FIR_CFG_RANGE_CHECK_EN, write 0x101=0 -> cfg_err=1, shadow down_sample keeps prior value after commit.

Source files
------------

// File: rtl/fir_cfg_ctrl.sv
// rtl/fir_cfg_ctrl.sv - FIR host config with ping-pong coefficient banks and sample-aligned atomic commit.
// Optional FIR_CFG_RANGE_CHECK_EN rejects zero tap_len/down_sample writes.
module fir_cfg_ctrl #(
    parameter int COEF_AW = 8
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [9:0]         cfg_addr,
    input  logic [31:0]        cfg_data,
    input  logic               sample_tick,
    output logic               coef_wr_en,
    output logic [COEF_AW:0]   coef_wr_addr,
    output logic [31:0]        coef_wr_data,
    output logic               active_bank,
    output logic [7:0]         tap_len,
    output logic [7:0]         down_sample,
    output logic               bypass,
    output logic [3:0]         pcm_out_shift,
    output logic               busy,
    output logic               commit_done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {IDLE, PENDING, SWAP} state_t;

    state_t     state, state_nxt;
    logic       accept;
    logic       is_coef, is_tap, is_ds, is_ctl, is_commit, is_bad, bad_val;
    logic [7:0] sh_tap, sh_ds;
    logic       sh_bypass;
    logic [3:0] sh_shift;

    assign is_coef   = (cfg_addr[9:8] == 2'b00);
    assign is_tap    = (cfg_addr == 10'h100);
    assign is_ds     = (cfg_addr == 10'h101);
    assign is_ctl    = (cfg_addr == 10'h102);
    assign is_commit = (cfg_addr == 10'h103);
    assign is_bad    = !(is_coef || is_tap || is_ds || is_ctl || is_commit);
    assign accept    = cfg_valid && cfg_ready;

`ifdef FIR_CFG_RANGE_CHECK_EN
    assign bad_val = (is_tap || is_ds) && (cfg_data[7:0] == 8'd0);
`else
    assign bad_val = 1'b0;
`endif

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // sample_tick is only looked at in PENDING, so a tick coinciding with the commit is ignored
    always_comb begin
        state_nxt   = state;
        cfg_ready   = 1'b0;
        busy        = 1'b0;
        commit_done = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = !rst;
                if (cfg_valid && !rst && is_commit) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                busy = 1'b1;
                if (sample_tick) begin
                    state_nxt = SWAP;
                end
            end
            SWAP: begin
                busy        = 1'b1;
                commit_done = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            coef_wr_en    <= 1'b0;
            coef_wr_addr  <= '0;
            coef_wr_data  <= '0;
            cfg_err       <= 1'b0;
            sh_tap        <= 8'd1;
            sh_ds         <= 8'd1;
            sh_bypass     <= 1'b1;
            sh_shift      <= 4'd0;
            active_bank   <= 1'b0;
            tap_len       <= 8'd1;
            down_sample   <= 8'd1;
            bypass        <= 1'b1;
            pcm_out_shift <= 4'd0;
        end else begin
            coef_wr_en <= accept && is_coef;
            // writes always target the bank the lanes are not reading
            if (accept && is_coef) begin
                coef_wr_addr <= {~active_bank, cfg_addr[COEF_AW-1:0]};
                coef_wr_data <= cfg_data;
            end
            if (accept && (is_bad || bad_val)) begin
                cfg_err <= 1'b1;
            end
            if (accept && !bad_val) begin
                if (is_tap) sh_tap <= cfg_data[7:0];
                if (is_ds)  sh_ds  <= cfg_data[7:0];
                if (is_ctl) begin
                    sh_bypass <= cfg_data[4];
                    sh_shift  <= cfg_data[3:0];
                end
            end
            if (state == SWAP) begin
                active_bank   <= ~active_bank;
                tap_len       <= sh_tap;
                down_sample   <= sh_ds;
                bypass        <= sh_bypass;
                pcm_out_shift <= sh_shift;
            end
        end
    end

endmodule
